dpram_port_arbiter: RTL and testbench

Round-robin arbiter that shares one port of the 4096 x 8 dual-port RAM between two requesters, e.g. CPU and DMA, in a single clock domain. Each requester issues single-byte read or write transactions over a req/ack handshake. The arbiter latches the winning request, drives the RAM port for exactly one access cycle and captures read data. It then returns a one-cycle ack with the data. A top-level wrapper converts the separate ram_wdata/ram_rdata pins to the RAM's bidirectional data pin using ram_wena.

---
 rtl/dpram_port_arbiter.sv | 165 ++++++++++++++++
 tb/tb_dpram_port_arbiter.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one port of a 4096 x 8 dual-port RAM between
// two requesters. Each transaction: grant in IDLE, one ACCESS cycle where the
// RAM samples the port, one CAPTURE cycle for read data, then a one-cycle ack.
module dpram_port_arbiter #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wena,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              busy,
    output logic              gnt_id
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_q, last_d;
    logic              gnt_id_q, gnt_id_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              ram_wena_q, ram_wena_d;
    logic [ADDR_W-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_W-1:0] ram_wdata_q, ram_wdata_d;
    logic              p0_ack_q, p0_ack_d;
    logic              p1_ack_q, p1_ack_d;
    logic [DATA_W-1:0] p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0] p1_rdata_q, p1_rdata_d;

    // A requester being acked this cycle is ignored so a held req is not
    // mistaken for a fresh transaction.
    logic m0, m1, grant, winner;
    assign m0     = p0_req & ~p0_ack_q;
    assign m1     = p1_req & ~p1_ack_q;
    assign grant  = (state_q == IDLE) && (m0 || m1);
    assign winner = (m0 && m1) ? ~last_q : m1;

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: IDLE -> ACCESS -> CAPTURE -> IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant) state_d = ACCESS;
            ACCESS:  state_d = CAPTURE;
            CAPTURE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output logic: latch the winner at grant, pulse ack and capture read data
    always_comb begin
        last_d      = last_q;
        gnt_id_d    = gnt_id_q;
        we_d        = we_q;
        busy_d      = 1'b0;
        ram_wena_d  = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_wdata_d = ram_wdata_q;
        p0_ack_d    = 1'b0;
        p1_ack_d    = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    busy_d   = 1'b1;
                    last_d   = winner;
                    gnt_id_d = winner;
                    if (winner) begin
                        we_d        = p1_we;
                        ram_wena_d  = p1_we;
                        ram_addr_d  = p1_addr;
                        ram_wdata_d = p1_wdata;
                    end else begin
                        we_d        = p0_we;
                        ram_wena_d  = p0_we;
                        ram_addr_d  = p0_addr;
                        ram_wdata_d = p0_wdata;
                    end
                end
            end
            ACCESS: begin
                busy_d = 1'b1;
            end
            CAPTURE: begin
                if (gnt_id_q) begin
                    p1_ack_d = 1'b1;
                    if (!we_q) p1_rdata_d = ram_rdata;
                end else begin
                    p0_ack_d = 1'b1;
                    if (!we_q) p0_rdata_d = ram_rdata;
                end
            end
            default: ;
        endcase
    end

    // Registered outputs and latched transaction; last resets to 1 so
    // requester 0 wins the first tie.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_q      <= 1'b1;
            gnt_id_q    <= 1'b0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            ram_wena_q  <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            p0_ack_q    <= 1'b0;
            p1_ack_q    <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            last_q      <= last_d;
            gnt_id_q    <= gnt_id_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            ram_wena_q  <= ram_wena_d;
            ram_addr_q  <= ram_addr_d;
            ram_wdata_q <= ram_wdata_d;
            p0_ack_q    <= p0_ack_d;
            p1_ack_q    <= p1_ack_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
        end
    end

    assign p0_ack    = p0_ack_q;
    assign p1_ack    = p1_ack_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wena  = ram_wena_q;
    assign ram_wdata = ram_wdata_q;
    assign busy      = busy_q;
    assign gnt_id    = gnt_id_q;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Bench for dpram_port_arbiter: scripted and random requesters, a RAM
// stand-in on the port, and a timestamp-based transaction model.
module tb_dpram_port_arbiter;
    localparam int AW = 12;
    localparam int DW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wdata, p1_wdata;
    logic          p0_ack, p1_ack;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] ram_addr;
    logic          ram_wena;
    logic [DW-1:0] ram_wdata, ram_rdata;
    logic          busy, gnt_id;

    dpram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset_n(reset_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .ram_addr(ram_addr), .ram_wena(ram_wena), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .busy(busy), .gnt_id(gnt_id)
    );

    // RAM stand-in: synchronous write, registered read
    bit [DW-1:0] ram_mem [0:4095];
    always @(posedge clk) begin
        if (ram_wena) ram_mem[ram_addr] <= ram_wdata;
        ram_rdata <= ram_mem[ram_addr];
    end

    // ---------------- reference model (timestamps of the last grant) -------
    bit [DW-1:0]   ref_mem [0:4095];
    int            cyc;
    bit            g_valid;
    int            g_t;
    bit            g_p, g_we, last_w;
    logic [AW-1:0] g_addr;
    logic [DW-1:0] g_wdata, g_rd;
    logic          e_busy, e_wena, e_gnt;
    bit   [1:0]    e_ack;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_wdata;
    logic [DW-1:0] e_rdata [2];

    // ---------------- requester drivers -----------------------------------
    typedef struct packed {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic          drop;
    } txn_t;
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur [2];
    bit [1:0] active, granted;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic txn_t mk(input logic we, input logic [AW-1:0] addr,
                                input logic [DW-1:0] wdata, input logic drop);
        txn_t t;
        t.we = we; t.addr = addr; t.wdata = wdata; t.drop = drop;
        return t;
    endfunction

    task automatic model_reset();
        g_valid = 1'b0; g_t = 0; g_p = 1'b0; g_we = 1'b0; last_w = 1'b1;
        g_addr = '0; g_wdata = '0; g_rd = '0;
        e_busy = 1'b0; e_wena = 1'b0; e_gnt = 1'b0; e_ack = 2'b00;
        e_addr = '0; e_wdata = '0; e_rdata[0] = '0; e_rdata[1] = '0;
    endtask

    // Advance the model across one clock edge using this cycle's inputs.
    task automatic model_edge();
        bit m0, m1, win;
        cyc++;
        m0 = p0_req & ~e_ack[0];
        m1 = p1_req & ~e_ack[1];
        if (g_valid && cyc == g_t + 1) begin
            if (g_we) ref_mem[g_addr] = g_wdata;
            else      g_rd = ref_mem[g_addr];
        end
        if (g_valid && cyc == g_t + 2 && !g_we) e_rdata[g_p] = g_rd;
        if ((!g_valid || cyc >= g_t + 3) && (m0 || m1)) begin
            win     = (m0 && m1) ? ~last_w : m1;
            g_valid = 1'b1;
            g_t     = cyc;
            g_p     = win;
            last_w  = win;
            g_we    = win ? p1_we    : p0_we;
            g_addr  = win ? p1_addr  : p0_addr;
            g_wdata = win ? p1_wdata : p0_wdata;
            granted[win] = 1'b1;
        end
        e_busy   = g_valid && (cyc == g_t || cyc == g_t + 1);
        e_wena   = g_valid && cyc == g_t && g_we;
        e_ack[0] = g_valid && cyc == g_t + 2 && !g_p;
        e_ack[1] = g_valid && cyc == g_t + 2 && g_p;
        if (g_valid) begin
            e_addr = g_addr; e_wdata = g_wdata; e_gnt = g_p;
        end
    endtask

    task automatic drive_inputs();
        bit show0, show1;
        for (int p = 0; p < 2; p++) begin
            if (e_ack[p]) active[p] = 1'b0;
        end
        if (!active[0] && q0.size() > 0) begin
            cur[0] = q0.pop_front(); active[0] = 1'b1; granted[0] = 1'b0;
        end
        if (!active[1] && q1.size() > 0) begin
            cur[1] = q1.pop_front(); active[1] = 1'b1; granted[1] = 1'b0;
        end
        show0 = active[0] && !(granted[0] && cur[0].drop);
        show1 = active[1] && !(granted[1] && cur[1].drop);
        p0_req   = show0;
        p0_we    = show0 ? cur[0].we    : 1'($urandom);
        p0_addr  = show0 ? cur[0].addr  : AW'($urandom);
        p0_wdata = show0 ? cur[0].wdata : DW'($urandom);
        p1_req   = show1;
        p1_we    = show1 ? cur[1].we    : 1'($urandom);
        p1_addr  = show1 ? cur[1].addr  : AW'($urandom);
        p1_wdata = show1 ? cur[1].wdata : DW'($urandom);
    endtask

    task automatic check_outputs();
        check_eq("busy",      32'(busy),      32'(e_busy));
        check_eq("ram_wena",  32'(ram_wena),  32'(e_wena));
        check_eq("ram_addr",  32'(ram_addr),  32'(e_addr));
        check_eq("ram_wdata", 32'(ram_wdata), 32'(e_wdata));
        check_eq("gnt_id",    32'(gnt_id),    32'(e_gnt));
        check_eq("p0_ack",    32'(p0_ack),    32'(e_ack[0]));
        check_eq("p1_ack",    32'(p1_ack),    32'(e_ack[1]));
        check_eq("p0_rdata",  32'(p0_rdata),  32'(e_rdata[0]));
        check_eq("p1_rdata",  32'(p1_rdata),  32'(e_rdata[1]));
        if (e_ack != 2'b00)
            $display("cycle %0d: p%0d %s addr 0x%03h data 0x%02h", cyc, g_p,
                     g_we ? "write" : "read ", g_addr, g_we ? g_wdata : g_rd);
    endtask

    task automatic step();
        drive_inputs();
        @(posedge clk);
        model_edge();
        #1;
        check_outputs();
    endtask

    task automatic drain(input int limit);
        int  n;
        bit  done;
        n = 0;
        done = 1'b0;
        while (!done && n < limit) begin
            step();
            n++;
            done = q0.size() == 0 && q1.size() == 0 && active == 2'b00 &&
                   !e_busy && e_ack == 2'b00;
        end
        check_eq("drain_done", 32'(done), 32'd1);
    endtask

    // Asserted mid-cycle, held across one edge, released on a falling edge.
    task automatic apply_reset();
        reset_n = 1'b0;
        model_reset();
        q0.delete(); q1.delete();
        active = 2'b00; granted = 2'b00;
        p0_req = 1'b0; p1_req = 1'b0;
        #1;
        check_outputs();
        @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    initial begin
        int ndiff;
        logic [AW-1:0] a;
        cyc = 0;
        active = 2'b00; granted = 2'b00;
        reset_n = 1'b0;
        p0_req = 1'b0; p0_we = 1'b0; p0_addr = '0; p0_wdata = '0;
        p1_req = 1'b0; p1_we = 1'b0; p1_addr = '0; p1_wdata = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        @(negedge clk);
        reset_n = 1'b1;

        // Single write then read-back by requester 0
        q0.push_back(mk(1'b1, 12'h123, 8'hA5, 1'b0));
        q0.push_back(mk(1'b0, 12'h123, 8'h00, 1'b0));
        drain(40);
        check_eq("t1_readback", 32'(p0_rdata), 32'h0A5);

        // req held across ack with a new address
        q0.push_back(mk(1'b0, 12'h010, 8'h00, 1'b0));
        q0.push_back(mk(1'b0, 12'h011, 8'h00, 1'b0));
        drain(40);

        // Both requesters busy for 8 transactions
        for (int i = 0; i < 4; i++) begin
            q0.push_back(mk(1'($urandom), AW'(i),      DW'($urandom), 1'b0));
            q1.push_back(mk(1'($urandom), AW'(i + 2),  DW'($urandom), 1'b0));
        end
        drain(80);

        // Random traffic, including requests dropped after grant
        for (int c = 0; c < 400; c++) begin
            if (q0.size() == 0 && !active[0] && $urandom_range(0, 2) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15))
                                                : AW'(32'hFF0 + $urandom_range(0, 15));
                q0.push_back(mk(1'($urandom), a, DW'($urandom), $urandom_range(0, 3) == 0));
            end
            if (q1.size() == 0 && !active[1] && $urandom_range(0, 2) == 0) begin
                a = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15))
                                                : AW'(32'hFF0 + $urandom_range(0, 15));
                q1.push_back(mk(1'($urandom), a, DW'($urandom), $urandom_range(0, 3) == 0));
            end
            step();
        end
        drain(60);

        // Address boundaries
        q0.push_back(mk(1'b1, 12'h000, 8'h00, 1'b0));
        q0.push_back(mk(1'b0, 12'h000, 8'h00, 1'b0));
        q1.push_back(mk(1'b1, 12'hFFF, 8'hFF, 1'b0));
        q1.push_back(mk(1'b0, 12'hFFF, 8'h00, 1'b0));
        drain(60);
        check_eq("t5_rd_000", 32'(p0_rdata), 32'h000);
        check_eq("t5_rd_fff", 32'(p1_rdata), 32'h0FF);

        // Simultaneous reads straight after reset: p0 first, then p1
        @(posedge clk);
        #1;
        apply_reset();
        q0.push_back(mk(1'b0, 12'hFFF, 8'h00, 1'b0));
        q1.push_back(mk(1'b0, 12'h001, 8'h00, 1'b0));
        step();
        check_eq("t2_first_gnt", 32'(gnt_id), 32'd0);
        repeat (3) step();
        check_eq("t2_second_gnt", 32'(gnt_id), 32'd1);
        drain(40);

        // Reset during ACCESS of a write to 0x200
        q0.push_back(mk(1'b1, 12'h200, 8'h77, 1'b0));
        for (int i = 0; i < 10 && !e_wena; i++) step();
        check_eq("t6_wena_before_rst", 32'(ram_wena), 32'd1);
        apply_reset();
        q1.push_back(mk(1'b0, 12'h200, 8'h00, 1'b0));
        step();
        check_eq("t6_busy_after_rst", 32'(busy), 32'd1);
        check_eq("t6_gnt_after_rst", 32'(gnt_id), 32'd1);
        drain(40);
        check_eq("t6_write_lost", 32'(p1_rdata), 32'h000);

        ndiff = 0;
        for (int i = 0; i < 4096; i++) begin
            if (ram_mem[i] != ref_mem[i]) ndiff++;
        end
        check_eq("mem_diffs", 32'(ndiff), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
